// File: rtl/sb_pkg.sv
// rtl/sb_pkg.sv - shared types and helpers for the sideband TX pattern engine
package sb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SEND    = 3'd1,
    ST_GAP     = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_DONE    = 3'd4,
    ST_TIMEOUT = 3'd5
  } sb_pat_state_e;

  // Widest pattern word the helper can build; callers slice down to their width.
  localparam int unsigned SB_PAT_MAX_W = 1024;

  // Clock pattern: alternating 1/0 with bit 0 = 0, zero above bit w-1.
  function automatic logic [SB_PAT_MAX_W-1:0] clk_pattern(input int unsigned w);
    logic [SB_PAT_MAX_W-1:0] pat;
    pat = '0;
    for (int unsigned i = 0; i < SB_PAT_MAX_W; i++) begin
      if (i < w) pat[i] = i[0];
    end
    return pat;
  endfunction

endpackage

// File: rtl/sb_ms_slot_timer.sv
// rtl/sb_ms_slot_timer.sv - 1 ms slot timer with slot counter and expiry
module sb_ms_slot_timer #(
  parameter int unsigned CLK_PER_MS = 100,
  parameter int unsigned TIMEOUT_MS = 8
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic clear_i,
  input  logic freeze_i,
  output logic tick_o,
  output logic expire_o
);

  localparam int unsigned MS_W   = $clog2(CLK_PER_MS);
  localparam int unsigned SLOT_W = $clog2(TIMEOUT_MS + 1);
  localparam logic [MS_W-1:0]   MS_LAST   = MS_W'(CLK_PER_MS - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(TIMEOUT_MS - 1);

  logic [MS_W-1:0]   ms_cnt_q, ms_cnt_d;
  logic [SLOT_W-1:0] slot_cnt_q, slot_cnt_d;

  // tick marks the last cycle of a slot; expire marks the wrap of the final slot
  assign tick_o   = !clear_i && !freeze_i && (ms_cnt_q == MS_LAST);
  assign expire_o = tick_o && (slot_cnt_q == SLOT_LAST);

  // Counter advance: clear wins, freeze holds, otherwise count and wrap into the next slot
  always_comb begin
    ms_cnt_d   = ms_cnt_q;
    slot_cnt_d = slot_cnt_q;
    if (clear_i) begin
      ms_cnt_d   = '0;
      slot_cnt_d = '0;
    end else if (!freeze_i) begin
      if (ms_cnt_q == MS_LAST) begin
        ms_cnt_d   = '0;
        slot_cnt_d = slot_cnt_q + 1'b1;
      end else begin
        ms_cnt_d = ms_cnt_q + 1'b1;
      end
    end
  end

  // Counter registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ms_cnt_q   <= '0;
      slot_cnt_q <= '0;
    end else begin
      ms_cnt_q   <= ms_cnt_d;
      slot_cnt_q <= slot_cnt_d;
    end
  end

endmodule

// File: rtl/sb_tx_pattern_engine.sv
// rtl/sb_tx_pattern_engine.sv - sideband TX clock-pattern engine with burst/continuous modes
module sb_tx_pattern_engine
  import sb_pkg::*;
#(
  parameter int unsigned PATTERN_W   = 64,
  parameter int unsigned CLK_PER_MS  = 100,
  parameter int unsigned TIMEOUT_MS  = 8,
  parameter int unsigned EXTRA_ITERS = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start_req,
  input  logic                 i_abort,
  input  logic                 i_mode,
  input  logic                 i_rx_samp_done,
  input  logic                 i_ser_ready,
  output logic [PATTERN_W-1:0] o_pattern,
  output logic                 o_pattern_valid,
  output logic                 o_done,
  output logic                 o_timeout,
  output logic                 o_busy
);

  localparam logic [SB_PAT_MAX_W-1:0] PAT_FULL = clk_pattern(PATTERN_W);
  localparam logic [PATTERN_W-1:0]    PAT      = PAT_FULL[PATTERN_W-1:0];
  localparam int unsigned             DRAIN_W  = $clog2(EXTRA_ITERS + 1);
  localparam logic [DRAIN_W-1:0]      DRAIN_LAST = DRAIN_W'(EXTRA_ITERS - 1);

  sb_pat_state_e      state_q, state_d;
  logic               mode_q, mode_d;
  logic               valid_q, valid_d;
  logic               done_q, done_d;
  logic               timeout_q, timeout_d;
  logic [DRAIN_W-1:0] drain_cnt_q, drain_cnt_d;
  logic               tick, expire, xfer, in_slot, timer_clear;

  assign xfer        = valid_q && i_ser_ready;
  assign in_slot     = (state_q == ST_SEND) || (state_q == ST_GAP);
  assign timer_clear = (state_q == ST_IDLE);

  sb_ms_slot_timer #(
    .CLK_PER_MS (CLK_PER_MS),
    .TIMEOUT_MS (TIMEOUT_MS)
  ) u_timer (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .clear_i  (timer_clear),
    .freeze_i (!in_slot),
    .tick_o   (tick),
    .expire_o (expire)
  );

  // Next-state and registered-output decisions; abort overrides everything
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    drain_cnt_d = drain_cnt_q;
    valid_d     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        drain_cnt_d = '0;
        if (i_start_req) begin
          state_d = ST_SEND;
          mode_d  = i_mode;
        end
      end
      ST_SEND, ST_GAP: begin
        drain_cnt_d = '0;
        if (i_rx_samp_done)      state_d = ST_DRAIN;
        else if (expire)         state_d = ST_TIMEOUT;
        else if (tick && !mode_q) state_d = (state_q == ST_SEND) ? ST_GAP : ST_SEND;
      end
      ST_DRAIN: begin
        if (xfer) begin
          drain_cnt_d = drain_cnt_q + 1'b1;
          if (drain_cnt_q == DRAIN_LAST) state_d = ST_DONE;
        end
      end
      ST_DONE, ST_TIMEOUT: state_d = ST_IDLE;
      default:             state_d = ST_IDLE;
    endcase
    if (i_abort) state_d = ST_IDLE;

    // A pending word survives slot changes; new words come only from SEND or DRAIN
    if ((state_d == ST_SEND) || (state_d == ST_GAP) || (state_d == ST_DRAIN)) begin
      if (valid_q && !i_ser_ready)                          valid_d = 1'b1;
      else if ((state_q == ST_SEND) || (state_q == ST_DRAIN)) valid_d = 1'b1;
    end
    done_d    = (state_q == ST_DONE) && !i_abort;
    timeout_d = (state_q == ST_TIMEOUT) && !i_abort;
  end

  // State and output registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      mode_q      <= 1'b0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      drain_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      valid_q     <= valid_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  assign o_pattern       = valid_q ? PAT : '0;
  assign o_pattern_valid = valid_q;
  assign o_done          = done_q;
  assign o_timeout       = timeout_q;
  assign o_busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sb_tx_pattern_engine.sv
// tb/tb_sb_tx_pattern_engine.sv - self-checking bench for sb_tx_pattern_engine
module tb_sb_tx_pattern_engine;

  localparam int unsigned PW    = 64;
  localparam int unsigned CPM   = 100;
  localparam int unsigned TMS   = 8;
  localparam int unsigned EXTRA = 4;
  localparam logic [63:0] PAT_EXP = 64'hAAAA_AAAA_AAAA_AAAA;

  logic i_clk = 1'b0;
  logic i_rst_n = 1'b0;
  logic i_start_req = 1'b0;
  logic i_abort = 1'b0;
  logic i_mode = 1'b0;
  logic i_rx_samp_done = 1'b0;
  logic i_ser_ready = 1'b0;
  logic [PW-1:0] o_pattern;
  logic o_pattern_valid, o_done, o_timeout, o_busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_xfer = 0;
  int n_done = 0;
  int n_to = 0;

  // Model: phase 0 idle, 1 running slots, 2 draining, 3 done cycle, 4 timeout cycle
  int   m_phase = 0;
  int   m_t = 0;
  int   m_drains = 0;
  logic m_mode = 1'b0;
  logic m_valid = 1'b0;
  logic m_done = 1'b0;
  logic m_to = 1'b0;

  always #5 i_clk = ~i_clk;

  sb_tx_pattern_engine #(
    .PATTERN_W   (PW),
    .CLK_PER_MS  (CPM),
    .TIMEOUT_MS  (TMS),
    .EXTRA_ITERS (EXTRA)
  ) dut (
    .i_clk           (i_clk),
    .i_rst_n         (i_rst_n),
    .i_start_req     (i_start_req),
    .i_abort         (i_abort),
    .i_mode          (i_mode),
    .i_rx_samp_done  (i_rx_samp_done),
    .i_ser_ready     (i_ser_ready),
    .o_pattern       (o_pattern),
    .o_pattern_valid (o_pattern_valid),
    .o_done          (o_done),
    .o_timeout       (o_timeout),
    .o_busy          (o_busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_cycle();
    logic sending, pend, xfer;
    cyc++;
    if (!i_rst_n) begin
      m_phase = 0; m_t = 0; m_drains = 0;
      m_valid = 1'b0; m_done = 1'b0; m_to = 1'b0;
    end
    chk("valid", o_pattern_valid, m_valid);
    chk("done", o_done, m_done);
    chk("timeout", o_timeout, m_to);
    chk("busy", o_busy, m_phase != 0);
    if (m_valid) chk("pattern", o_pattern, PAT_EXP);
    if (o_pattern_valid && i_ser_ready) n_xfer++;
    if (o_done) n_done++;
    if (o_timeout) n_to++;
    if (!i_rst_n) return;
    xfer   = m_valid && i_ser_ready;
    pend   = m_valid && !i_ser_ready;
    m_done = 1'b0;
    m_to   = 1'b0;
    if (i_abort) begin
      m_phase = 0;
      m_valid = 1'b0;
    end else begin
      case (m_phase)
        0: begin
          m_valid = 1'b0;
          if (i_start_req) begin m_phase = 1; m_t = 0; m_mode = i_mode; end
        end
        1: begin
          sending = m_mode || (((m_t / CPM) % 2) == 0);
          if (i_rx_samp_done) begin
            m_phase = 2; m_drains = 0; m_valid = pend || sending;
          end else if (m_t == CPM * TMS - 1) begin
            m_phase = 4; m_valid = 1'b0;
          end else begin
            m_t++; m_valid = pend || sending;
          end
        end
        2: begin
          if (xfer) m_drains++;
          if (m_drains == EXTRA) begin m_phase = 3; m_valid = 1'b0; end
          else m_valid = 1'b1;
        end
        3: begin m_phase = 0; m_done = 1'b1; m_valid = 1'b0; end
        default: begin m_phase = 0; m_to = 1'b1; m_valid = 1'b0; end
      endcase
    end
  endtask

  task automatic step();
    @(negedge i_clk);
    model_cycle();
    @(posedge i_clk);
    #1;
  endtask

  task automatic step_n(input int n, input bit toggle);
    for (int i = 0; i < n; i++) begin
      if (toggle) i_ser_ready = ~i_ser_ready;
      step();
    end
  endtask

  task automatic start(input logic mode);
    i_mode = mode;
    i_start_req = 1'b1;
    step();
    i_start_req = 1'b0;
  endtask

  task automatic wait_idle(input string name, input bit toggle);
    int k;
    k = 0;
    while (o_busy && k < 2000) begin
      if (toggle) i_ser_ready = ~i_ser_ready;
      step();
      k++;
    end
    chk({name, "_idle"}, o_busy, 1'b0);
    step();
    step();
  endtask

  task automatic cont_timeout_run(input string name);
    int k, x0, t0, d0;
    i_ser_ready = 1'b1;
    x0 = n_xfer; t0 = n_to; d0 = n_done;
    start(1'b1);
    k = 0;
    while (!o_pattern_valid && k < 10) begin step(); k++; end
    chk({name, "_latency"}, k, 1);
    k = 0;
    while (!o_timeout && k < 1000) begin step(); k++; end
    chk({name, "_timeout_dist"}, k, 800);
    chk({name, "_busy_after"}, o_busy, 1'b0);
    step();
    chk({name, "_xfers"}, n_xfer - x0, 799);
    chk({name, "_to_pulses"}, n_to - t0, 1);
    chk({name, "_done_pulses"}, n_done - d0, 0);
  endtask

  initial begin
    int x0, xd, t0, d0;
    step();
    chk("rst_pattern", o_pattern, 64'h0);
    chk("rst_busy", o_busy, 1'b0);
    step();
    i_rst_n = 1'b1;
    step_n(3, 1'b0);

    // A: continuous, always ready, no detect
    cont_timeout_run("A");

    // B: burst, always ready
    i_ser_ready = 1'b1;
    x0 = n_xfer; t0 = n_to; d0 = n_done;
    start(1'b0);
    step_n(100, 1'b0);
    chk("B_valid_c100", o_pattern_valid, 1'b1);
    step();
    chk("B_valid_c101", o_pattern_valid, 1'b0);
    wait_idle("B", 1'b0);
    chk("B_xfers", n_xfer - x0, 400);
    chk("B_to_pulses", n_to - t0, 1);
    chk("B_done_pulses", n_done - d0, 0);

    // C: burst, detect in the first GAP slot, ready toggling
    i_ser_ready = 1'b1;
    t0 = n_to; d0 = n_done;
    start(1'b0);
    step_n(150, 1'b1);
    i_rx_samp_done = 1'b1;
    step();
    i_rx_samp_done = 1'b0;
    xd = n_xfer;
    wait_idle("C", 1'b1);
    chk("C_drain_xfers", n_xfer - xd, 4);
    chk("C_done_pulses", n_done - d0, 1);
    chk("C_to_pulses", n_to - t0, 0);

    // D: detect late in the last GAP so draining spans the timeout mark
    i_ser_ready = 1'b1;
    t0 = n_to; d0 = n_done;
    start(1'b0);
    step_n(797, 1'b1);
    i_rx_samp_done = 1'b1;
    step();
    i_rx_samp_done = 1'b0;
    xd = n_xfer;
    wait_idle("D", 1'b1);
    chk("D_drain_xfers", n_xfer - xd, 4);
    chk("D_done_pulses", n_done - d0, 1);
    chk("D_to_pulses", n_to - t0, 0);

    // E: detect on the same cycle as the final slot wrap
    i_ser_ready = 1'b1;
    t0 = n_to; d0 = n_done;
    start(1'b1);
    step_n(799, 1'b0);
    i_rx_samp_done = 1'b1;
    step();
    i_rx_samp_done = 1'b0;
    xd = n_xfer;
    wait_idle("E", 1'b0);
    chk("E_drain_xfers", n_xfer - xd, 4);
    chk("E_done_pulses", n_done - d0, 1);
    chk("E_to_pulses", n_to - t0, 0);

    // F: word pending across the SEND-to-GAP boundary
    i_ser_ready = 1'b1;
    t0 = n_to; d0 = n_done;
    start(1'b0);
    step_n(99, 1'b0);
    i_ser_ready = 1'b0;
    x0 = n_xfer;
    step_n(41, 1'b0);
    chk("F_valid_held", o_pattern_valid, 1'b1);
    step_n(10, 1'b0);
    i_ser_ready = 1'b1;
    step();
    chk("F_valid_dropped", o_pattern_valid, 1'b0);
    step_n(48, 1'b0);
    chk("F_boundary_xfers", n_xfer - x0, 1);
    i_abort = 1'b1;
    step();
    i_abort = 1'b0;
    chk("F_busy_abort", o_busy, 1'b0);
    step_n(2, 1'b0);
    chk("F_pulses", (n_to - t0) + (n_done - d0), 0);

    // G: abort mid-drain, then a fresh run
    i_ser_ready = 1'b0;
    t0 = n_to; d0 = n_done;
    start(1'b1);
    step_n(50, 1'b0);
    i_rx_samp_done = 1'b1;
    step();
    i_rx_samp_done = 1'b0;
    step_n(5, 1'b0);
    xd = n_xfer;
    i_ser_ready = 1'b1;
    step_n(2, 1'b0);
    i_ser_ready = 1'b0;
    step_n(3, 1'b0);
    i_abort = 1'b1;
    step();
    i_abort = 1'b0;
    chk("G_valid_abort", o_pattern_valid, 1'b0);
    chk("G_busy_abort", o_busy, 1'b0);
    step_n(3, 1'b0);
    chk("G_drain_xfers", n_xfer - xd, 2);
    chk("G_pulses", (n_to - t0) + (n_done - d0), 0);
    cont_timeout_run("G_restart");

    // H: reset mid-send, then a fresh run
    i_ser_ready = 1'b1;
    t0 = n_to; d0 = n_done;
    start(1'b1);
    step_n(300, 1'b0);
    i_rst_n = 1'b0;
    #1;
    chk("H_valid_rst", o_pattern_valid, 1'b0);
    chk("H_busy_rst", o_busy, 1'b0);
    step();
    i_rst_n = 1'b1;
    step_n(2, 1'b0);
    chk("H_pulses", (n_to - t0) + (n_done - d0), 0);
    cont_timeout_run("H_restart");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sb_tx_pattern_engine.md
Name: sb_tx_pattern_engine

Overview:
- Parametrised sideband TX pattern engine: the next generation of the sideband pattern generator.
- On an LTSM request it streams the clock pattern (alternating 1/0, LSB = 0) to the sideband serializer using a valid/ready handshake.
- Supports bursty (1 ms on / 1 ms off) and continuous modes.
- Completes after a configurable number of extra iterations once the local RX reports pattern detection; otherwise it times out. The LTSM can abort it at any time.

Parameters:
- PATTERN_W, 64, serializer word width; must be even, at least 2.
- CLK_PER_MS, 100, i_clk cycles per 1 ms slot; at least 2.
- TIMEOUT_MS, 8, number of 1 ms slots (send and gap both count) before timeout; at least 1.
- EXTRA_ITERS, 4, handshaked transfers sent after RX detect before done; at least 1.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_start_req  in  1  level/pulse start from LTSM; sampled only in IDLE.
- i_abort  in  1  synchronous abort to IDLE.
- i_mode  in  1  0 = burst (alternate send/gap slots), 1 = continuous; sampled at start.
- i_rx_samp_done  in  1  pulse from local SB RX: pattern detected.
- i_ser_ready  in  1  serializer can accept a word.
- o_pattern  out  PATTERN_W  pattern word; constant {PATTERN_W/2{2'b10}} while valid.
- o_pattern_valid  out  1  word offered.
- o_done  out  1  one-cycle pulse: extra iterations complete.
- o_timeout  out  1  one-cycle pulse: TIMEOUT_MS elapsed without detect.
- o_busy  out  1  high in every state except IDLE.

Behaviour:
- Reset: all outputs 0, state IDLE, all counters 0.
- Transfer: a transfer is o_pattern_valid && i_ser_ready on a rising edge. Once valid rises it holds until the transfer completes, even across a SEND-to-GAP slot boundary; o_pattern is stable meanwhile.
- Entering IDLE or TIMEOUT forces valid = 0 and drops any pending word.
- Registered outputs. o_pattern_valid rises the cycle after entry to SEND or DRAIN, i.e. one-cycle start latency.
- States: IDLE, SEND, GAP, DRAIN, DONE, TIMEOUT.
- IDLE: i_start_req=1 goes to SEND; latch i_mode; clear the ms cycle counter (ms_cnt) and the slot counter (slot_cnt).
- SEND and GAP:
  - ms_cnt counts 0..CLK_PER_MS-1 and wraps.
  - At wrap, slot_cnt increments. If slot_cnt reaches TIMEOUT_MS, go to TIMEOUT.
  - Otherwise, in burst mode SEND and GAP toggle at each wrap; in continuous mode the state stays SEND.
  - GAP issues no new valid.
- i_rx_samp_done in SEND or GAP: go to DRAIN and clear the drain counter. A word still pending is allowed to complete and counts toward the drain.
- DRAIN:
  - Continuous sending; slot timer frozen and cannot time out.
  - The drain counter (width $clog2(EXTRA_ITERS+1)) increments per transfer.
  - On the EXTRA_ITERS-th transfer, go to DONE.
  - Further i_rx_samp_done pulses are ignored.
- DONE: o_done=1 for exactly one cycle, then IDLE.
- TIMEOUT: o_timeout=1 for exactly one cycle, then IDLE.
- Simultaneous events:
  - i_rx_samp_done in the same cycle as the timeout wrap: samp_done wins and the next state is DRAIN.
  - i_abort has priority over everything: next state IDLE, no done/timeout pulse, valid cleared the next cycle.
  - i_start_req while busy: ignored.
  - i_start_req in the DONE/TIMEOUT cycle: ignored; sampled again in IDLE.
  - i_rx_samp_done in IDLE: ignored.
- Reset mid-operation: immediate return to reset values; no pulse is emitted.

Decomposition:
- Shared package sb_pkg holds the state enum typedef sb_pat_state_e and the function clk_pattern(W) returning the 1010 word.
- Natural sub-module: sb_ms_slot_timer. It wraps ms_cnt and slot_cnt, provides tick and expire outputs, and has clear and freeze inputs. The engine FSM stays in the top module.

Test Plan:
- Defaults, mode=1, ready=1, no detect: valid stays high and 64'hAAAA_AAAA_AAAA_AAAA is transferred every cycle. o_timeout pulses exactly 800 cycles after valid first rises; the engine then returns to IDLE with o_busy=0.
- Defaults, mode=0, ready=1: valid is high for 100 cycles, low for 100, and so on. Four SEND slots carry 400 transfers total; timeout fires at cycle 800.
- Detect in slot 2 (a GAP slot) with ready toggling 1/0: exactly 4 further transfers, then a single o_done pulse. No o_timeout pulse, even when DRAIN spans the 800-cycle mark.
- i_rx_samp_done on the same cycle as the 8th slot wrap: DRAIN is entered, o_done follows after 4 transfers, o_timeout stays 0.
- ready=0 with valid pending at a SEND-to-GAP boundary: valid holds through GAP until ready=1; exactly one transfer occurs.
- i_abort mid-DRAIN, and separately i_rst_n asserted mid-SEND: IDLE the next cycle (or immediately for reset), valid=0, no done/timeout pulse. A new start then restarts the timeout from 0.
